// File: rtl/cache_fill_fsm.sv
// Cache block fill engine: on a miss, streams one read request per cycle to a
// pipelined 16-bit memory, steers the in-order returned words into the cache
// data array and strobes the tag write together with the final word.
module cache_fill_fsm #(
    parameter int ADDR_WIDTH       = 16,
    parameter int WORD_OFFSET_BITS = 3
) (
    input  logic                        clk,
    input  logic                        rst,
    // cache controller side
    input  logic                        miss_detected,
    input  logic [ADDR_WIDTH-1:0]       miss_address,
    output logic                        fsm_busy,
    // memory request port
    output logic                        memory_enable,
    output logic [ADDR_WIDTH-1:0]       memory_address,
    // memory response port
    input  logic                        memory_data_valid,
    input  logic [15:0]                 memory_data,
    // cache array write side
    output logic                        write_data_array,
    output logic [WORD_OFFSET_BITS-1:0] data_array_offset,
    output logic [15:0]                 fill_data,
    output logic                        write_tag_array
);

    // Counters need one extra bit so "all words issued" is representable.
    localparam int CNT_W = WORD_OFFSET_BITS + 1;

    // Number of words in a block and index of the last one.
    localparam logic [CNT_W-1:0] WORDS_PER_BLOCK = {1'b1, {WORD_OFFSET_BITS{1'b0}}};
    localparam logic [CNT_W-1:0] LAST_WORD       = {1'b0, {WORD_OFFSET_BITS{1'b1}}};

    // Clears the byte-within-block bits of an address (block = 2*words bytes).
    localparam logic [ADDR_WIDTH-1:0] BLOCK_MASK =
        {{(ADDR_WIDTH-CNT_W){1'b1}}, {CNT_W{1'b0}}};

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } state_t;

    state_t                  state_q,     state_d;
    logic                    busy_q,      busy_d;
    logic [ADDR_WIDTH-1:0]   base_addr_q, base_addr_d;
    logic [CNT_W-1:0]        issue_cnt_q, issue_cnt_d;
    logic [CNT_W-1:0]        recv_cnt_q,  recv_cnt_d;

    logic                    in_fill;
    logic                    issue_en;
    logic                    recv_en;
    logic                    last_recv;
    logic [ADDR_WIDTH-1:0]   issue_offset;

    // Request/response qualifiers derived from the current state and counters.
    always_comb begin
        in_fill      = (state_q == FILL);
        issue_en     = in_fill && (issue_cnt_q < WORDS_PER_BLOCK);
        recv_en      = in_fill && memory_data_valid;
        last_recv    = recv_en && (recv_cnt_q == LAST_WORD);
        // Word index converted to a byte offset (16-bit words).
        issue_offset = {{(ADDR_WIDTH-CNT_W-1){1'b0}}, issue_cnt_q, 1'b0};
    end

    // Next-state logic: latch the block base on a miss, then count requests
    // and responses independently until the last word has come back.
    always_comb begin
        state_d     = state_q;
        busy_d      = busy_q;
        base_addr_d = base_addr_q;
        issue_cnt_d = issue_cnt_q;
        recv_cnt_d  = recv_cnt_q;

        case (state_q)
            IDLE: begin
                if (miss_detected) begin
                    state_d     = FILL;
                    busy_d      = 1'b1;
                    base_addr_d = miss_address & BLOCK_MASK;
                    issue_cnt_d = '0;
                    recv_cnt_d  = '0;
                end
            end
            FILL: begin
                // Miss inputs are deliberately ignored here: no restart.
                if (issue_en) begin
                    issue_cnt_d = issue_cnt_q + 1'b1;
                end
                if (recv_en) begin
                    recv_cnt_d = recv_cnt_q + 1'b1;
                end
                if (last_recv) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State register; reset may land mid-fill and simply abandons it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            busy_q      <= 1'b0;
            base_addr_q <= '0;
            issue_cnt_q <= '0;
            recv_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            busy_q      <= busy_d;
            base_addr_q <= base_addr_d;
            issue_cnt_q <= issue_cnt_d;
            recv_cnt_q  <= recv_cnt_d;
        end
    end

    // Output decode: requests and array writes are combinational so a
    // latency-1 memory can overlap issue and response in the same cycle.
    always_comb begin
        fsm_busy          = busy_q;
        memory_enable     = issue_en;
        memory_address    = issue_en ? (base_addr_q + issue_offset) : '0;
        write_data_array  = recv_en;
        data_array_offset = recv_cnt_q[WORD_OFFSET_BITS-1:0];
        // Gated so the data bus reads zero whenever no write is happening.
        fill_data         = recv_en ? memory_data : 16'h0000;
        write_tag_array   = last_recv;
    end

endmodule

// File: tb/tb_cache_fill_fsm.sv
// Bench for cache_fill_fsm: a pipelined memory model with programmable
// latency, a cycle-level reference of the fill protocol that pushes expected
// requests/writes into queues, and a monitor that pops and compares them.
module tb_cache_fill_fsm;

    logic        clk = 1'b0;
    logic        rst;
    logic        miss_detected;
    logic [15:0] miss_address;
    logic        fsm_busy;
    logic        memory_enable;
    logic [15:0] memory_address;
    logic        memory_data_valid;
    logic [15:0] memory_data;
    logic        write_data_array;
    logic [2:0]  data_array_offset;
    logic [15:0] fill_data;
    logic        write_tag_array;

    cache_fill_fsm #(.ADDR_WIDTH(16), .WORD_OFFSET_BITS(3)) dut (
        .clk               (clk),
        .rst               (rst),
        .miss_detected     (miss_detected),
        .miss_address      (miss_address),
        .fsm_busy          (fsm_busy),
        .memory_enable     (memory_enable),
        .memory_address    (memory_address),
        .memory_data_valid (memory_data_valid),
        .memory_data       (memory_data),
        .write_data_array  (write_data_array),
        .data_array_offset (data_array_offset),
        .fill_data         (fill_data),
        .write_tag_array   (write_tag_array)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Memory contents: a fixed scramble of the word address.
    function automatic logic [15:0] mem_word(input logic [15:0] a);
        return {a[7:0], a[15:8]} ^ 16'h5A3C;
    endfunction

    // ---------------- memory model ----------------
    typedef struct {
        int          due;
        logic [15:0] data;
    } ret_t;
    ret_t pend[$];
    int   last_due  = -1;
    int   lat_mode  = 0;     // 0: fixed latency, 1: random 1..6
    int   lat_fixed = 4;
    logic stray_req = 1'b0;

    initial begin
        memory_data_valid = 1'b0;
        memory_data       = 16'h0000;
        forever begin
            @(posedge clk);
            #2;
            if (stray_req) begin
                memory_data_valid = 1'b1;
                memory_data       = 16'hBEEF;
            end else if (pend.size() > 0 && pend[0].due <= cyc) begin
                memory_data_valid = 1'b1;
                memory_data       = pend[0].data;
                void'(pend.pop_front());
            end else begin
                memory_data_valid = 1'b0;
                memory_data       = 16'($urandom);
            end
        end
    end

    always @(negedge clk) begin
        int lat;
        int due;
        if (memory_enable) begin
            lat = (lat_mode != 0) ? int'($urandom_range(1, 6)) : lat_fixed;
            due = cyc + lat;
            if (due <= last_due) due = last_due + 1;
            last_due = due;
            pend.push_back('{due, mem_word(memory_address)});
        end
    end

    // ---------------- reference model + scoreboard monitor ----------------
    typedef struct {
        logic [2:0]  off;
        logic [15:0] data;
    } wr_t;
    logic [15:0] exp_req[$];
    wr_t         exp_wr[$];
    int          wr_cycles[$];
    int          tag_cycles[$];
    logic        m_fill   = 1'b0;
    int          m_issued = 0;
    int          m_recv   = 0;

    always @(negedge clk) begin
        logic        e_busy, e_en, e_wr, e_tag;
        logic [15:0] base, a;
        wr_t         w;
        e_busy = m_fill && !rst;
        e_en   = m_fill && !rst && (m_issued < 8);
        e_wr   = m_fill && !rst && memory_data_valid;
        e_tag  = e_wr && (m_recv == 7);
        check("fsm_busy", fsm_busy, e_busy);
        check("memory_enable", memory_enable, e_en);
        check("write_data_array", write_data_array, e_wr);
        check("write_tag_array", write_tag_array, e_tag);

        if (memory_enable) begin
            if (exp_req.size() == 0) begin
                n_checks++; n_fail++;
                $display("FAIL req_unexpected: got addr 0x%0h, expected no request (cycle %0d)", memory_address, cyc);
            end else begin
                a = exp_req.pop_front();
                check("memory_address", memory_address, a);
            end
        end else begin
            check("idle_address", memory_address, 16'h0000);
        end

        if (write_data_array) begin
            wr_cycles.push_back(cyc);
            if (exp_wr.size() == 0) begin
                n_checks++; n_fail++;
                $display("FAIL wr_unexpected: got off %0d data 0x%0h, expected no write (cycle %0d)", data_array_offset, fill_data, cyc);
            end else begin
                w = exp_wr.pop_front();
                check("data_array_offset", data_array_offset, w.off);
                check("fill_data", fill_data, w.data);
            end
        end
        if (write_tag_array) tag_cycles.push_back(cyc);

        // Advance the reference for the next cycle.
        if (rst) begin
            m_fill = 1'b0;
            exp_req.delete();
            exp_wr.delete();
        end else if (!m_fill) begin
            if (miss_detected) begin
                m_fill   = 1'b1;
                m_issued = 0;
                m_recv   = 0;
                base     = miss_address & 16'hFFF0;
                for (int i = 0; i < 8; i++) begin
                    exp_req.push_back(base + 16'(2 * i));
                    exp_wr.push_back('{3'(i), mem_word(base + 16'(2 * i))});
                end
            end
        end else begin
            if (m_issued < 8) m_issued++;
            if (memory_data_valid) begin
                m_recv++;
                if (m_recv == 8) m_fill = 1'b0;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_quiet(input string name);
        int n = 0;
        while ((m_fill || pend.size() > 0) && n < 2000) begin
            step();
            n++;
        end
        check({name, "_timeout"}, (n < 2000), 1'b1);
    endtask

    task automatic clear_logs();
        wr_cycles.delete();
        tag_cycles.delete();
    endtask

    task automatic timed_fill(input string name, input logic [15:0] addr, input int lat);
        int c0;
        lat_mode  = 0;
        lat_fixed = lat;
        clear_logs();
        miss_detected = 1'b1;
        miss_address  = addr;
        c0 = cyc;
        step();
        miss_detected = 1'b0;
        miss_address  = 16'($urandom);
        wait_quiet(name);
        check({name, "_nwr"}, wr_cycles.size(), 8);
        check({name, "_ntag"}, tag_cycles.size(), 1);
        if (wr_cycles.size() > 0) begin
            check({name, "_first_wr_cyc"}, wr_cycles[0] - c0, 1 + lat);
            check({name, "_last_wr_cyc"}, wr_cycles[wr_cycles.size()-1] - c0, 8 + lat);
        end
        if (tag_cycles.size() > 0) check({name, "_tag_cyc"}, tag_cycles[0] - c0, 8 + lat);
        $display("fill %s addr=0x%0h lat=%0d writes=%0d tags=%0d", name, addr, lat, wr_cycles.size(), tag_cycles.size());
    endtask

    initial begin
        int n;
        rst           = 1'b1;
        miss_detected = 1'b0;
        miss_address  = 16'h0000;
        step();
        step();
        check("rst_busy", fsm_busy, 1'b0);
        check("rst_mem_en", memory_enable, 1'b0);
        check("rst_mem_addr", memory_address, 16'h0000);
        check("rst_wr", write_data_array, 1'b0);
        check("rst_tag", write_tag_array, 1'b0);
        rst = 1'b0;
        step();

        // Basic fill and latency-1 overlap.
        timed_fill("basic", 16'h1234, 4);
        timed_fill("lat1", 16'h0A5E, 1);

        // Irregular in-order returns.
        for (int k = 0; k < 3; k++) begin
            lat_mode = 1;
            clear_logs();
            miss_detected = 1'b1;
            miss_address  = 16'($urandom);
            step();
            miss_detected = 1'b0;
            wait_quiet("irregular");
            check("irr_nwr", wr_cycles.size(), 8);
            check("irr_ntag", tag_cycles.size(), 1);
            if (tag_cycles.size() > 0 && wr_cycles.size() == 8)
                check("irr_tag_with_last", tag_cycles[0], wr_cycles[7]);
            $display("fill irregular #%0d writes=%0d tags=%0d", k, wr_cycles.size(), tag_cycles.size());
        end

        // Miss held through a fill with the address moved to the top block.
        lat_mode  = 0;
        lat_fixed = 3;
        clear_logs();
        miss_detected = 1'b1;
        miss_address  = 16'h5678;
        step();
        miss_address = 16'hFFF0;
        n = 0;
        while (m_fill && n < 200) begin
            step();
            n++;
        end
        check("held_first_timeout", (n < 200), 1'b1);
        step();
        miss_detected = 1'b0;
        wait_quiet("held");
        check("held_nwr", wr_cycles.size(), 16);
        check("held_ntag", tag_cycles.size(), 2);
        if (tag_cycles.size() == 2 && wr_cycles.size() == 16)
            check("held_tag2_with_last", tag_cycles[1], wr_cycles[15]);
        $display("fill held-miss writes=%0d tags=%0d", wr_cycles.size(), tag_cycles.size());

        // Asynchronous reset after three returned words.
        lat_fixed = 3;
        clear_logs();
        miss_detected = 1'b1;
        miss_address  = 16'h2468;
        step();
        miss_detected = 1'b0;
        n = 0;
        while (m_recv < 3 && n < 100) begin
            step();
            n++;
        end
        check("rst_mid_timeout", (n < 100), 1'b1);
        rst = 1'b1;
        #1;
        check("midrst_busy", fsm_busy, 1'b0);
        check("midrst_mem_en", memory_enable, 1'b0);
        check("midrst_mem_addr", memory_address, 16'h0000);
        check("midrst_wr", write_data_array, 1'b0);
        check("midrst_tag", write_tag_array, 1'b0);
        step();
        step();
        rst = 1'b0;
        wait_quiet("late_valids");
        check("midrst_nwr", wr_cycles.size(), 3);
        check("midrst_ntag", tag_cycles.size(), 0);
        $display("fill aborted-by-reset writes=%0d tags=%0d", wr_cycles.size(), tag_cycles.size());
        timed_fill("post_reset", 16'h9ABC, 2);

        // Stray valid while idle.
        stray_req = 1'b1;
        #2;
        check("stray_wr", write_data_array, 1'b0);
        check("stray_tag", write_tag_array, 1'b0);
        step();
        stray_req = 1'b0;
        $display("stray valid 0xBEEF in idle: wr=%0b tag=%0b", write_data_array, write_tag_array);

        // Random misses, including misses that arrive during fills.
        lat_mode = 1;
        clear_logs();
        for (int i = 0; i < 400; i++) begin
            miss_detected = ($urandom_range(0, 3) == 0);
            miss_address  = 16'($urandom);
            step();
        end
        miss_detected = 1'b0;
        wait_quiet("random");
        check("rand_wr_vs_tag", wr_cycles.size(), 8 * tag_cycles.size());
        check("rand_some_fills", (tag_cycles.size() > 0), 1'b1);
        $display("random phase fills=%0d writes=%0d", tag_cycles.size(), wr_cycles.size());

        step();
        check("exp_req_left", exp_req.size(), 0);
        check("exp_wr_left", exp_wr.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got time %0t, expected completion earlier", $time);
        $fatal(1, "watchdog");
    end

endmodule
